// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the banked data memory controller
package dmem_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  // A single bank still gets a 1-bit select so the pipeline register never collapses to zero width.
  function automatic int sel_width(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - single-port RAM bank with byte-enable write and registered read
module dmem_bank #(
  parameter int BANK_AW = 16,
  parameter int DATA_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [BANK_AW-1:0]    addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**BANK_AW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_data_mem_ctrl.sv
// rtl/banked_data_mem_ctrl.sv - decodes word addresses onto NUM_BANKS RAM banks
// with req/ready/rvalid handshake, error reporting and optional clear after reset.
module banked_data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int NUM_BANKS      = 4,
  parameter int BANK_AW        = 16,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic [NUM_BANKS-1:0]  bank_wren_o,
  output logic                  busy_clear_o
);

  localparam int SEL_W = sel_width(NUM_BANKS);
  localparam int NBE   = DATA_W / 8;
  localparam logic [BANK_AW-1:0] CLR_LAST = '1;

  state_e             state_q;
  logic [BANK_AW-1:0] clr_addr_q, clr_addr_d;
  logic               ready_q;
  logic               busy_q;
  logic               rd_pend_q;
  logic               err_pend_q;
  logic [SEL_W-1:0]   sel_q;

  logic [SEL_W-1:0]   bank_idx;
  logic               addr_err;
  logic               accept;
  logic               wr_hit;
  logic               rd_hit;
  logic               clearing;

  logic [BANK_AW-1:0] ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [NBE-1:0]     ram_be;
  logic [NUM_BANKS-1:0] bank_en;
  logic [NUM_BANKS-1:0] bank_we;
  logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];

  assign bank_idx = addr_i[BANK_AW +: SEL_W];
  assign addr_err = ((addr_i >> (BANK_AW + SEL_W)) != 32'd0) ||
                    (32'(bank_idx) >= 32'(NUM_BANKS));
  assign accept   = req_i && ready_q;
  assign wr_hit   = accept && we_i && !addr_err;
  assign rd_hit   = accept && !we_i && !addr_err;
  assign clearing = (state_q == S_CLEAR);

  assign clr_addr_d = clr_addr_q + 1'b1;

  // The clear sequence borrows every bank's port; requests are held off while it runs.
  assign ram_addr  = clearing ? clr_addr_q : addr_i[BANK_AW-1:0];
  assign ram_wdata = clearing ? '0 : wdata_i;
  assign ram_be    = clearing ? '1 : be_i;

  always_comb begin
    bank_wren_o = '0;
    bank_en     = '0;
    bank_we     = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_wren_o[i] = wr_hit && (bank_idx == SEL_W'(i));
      bank_we[i]     = clearing || bank_wren_o[i];
      bank_en[i]     = bank_we[i] || (rd_hit && (bank_idx == SEL_W'(i)));
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    dmem_bank #(
      .BANK_AW (BANK_AW),
      .DATA_W  (DATA_W)
    ) u_bank (
      .clk_i   (CLK),
      .en_i    (bank_en[g]),
      .we_i    (bank_we[g]),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .be_i    (ram_be),
      .rdata_o (bank_rdata[g])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= (CLEAR_ON_RESET != 0);
      rd_pend_q  <= 1'b0;
      err_pend_q <= 1'b0;
      sel_q      <= '0;
    end else begin
      rd_pend_q  <= rd_hit;
      err_pend_q <= accept && addr_err;
      if (rd_hit) begin
        sel_q <= bank_idx;
      end
      case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_d;
          if (clr_addr_q == CLR_LAST) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Select comes from the index captured at accept, so back-to-back reads to different banks stay aligned.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_pend_q && (sel_q == SEL_W'(i))) begin
        rdata_o = bank_rdata[i];
      end
    end
  end

  assign rvalid_o     = rd_pend_q || err_pend_q;
  assign err_o        = err_pend_q;
  assign ready_o      = ready_q;
  assign busy_clear_o = busy_q;

endmodule

// File: tb/tb_banked_data_mem_ctrl.sv
// tb/tb_banked_data_mem_ctrl.sv - directed scoreboard bench for banked_data_mem_ctrl
module tb_banked_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        req4, we4;
  logic [31:0] addr4, wd4;
  logic [3:0]  be4;
  logic        ready4, rvalid4, err4, busy4;
  logic [31:0] rdata4;
  logic [3:0]  wren4;

  logic        req3, we3;
  logic [31:0] addr3, wd3;
  logic [3:0]  be3;
  logic        ready3, rvalid3, err3, busy3;
  logic [31:0] rdata3;
  logic [2:0]  wren3;

  int checks = 0;
  int errors = 0;

  logic [32:0] q4[$];
  logic [32:0] q3[$];

  always #5 CLK = ~CLK;

  banked_data_mem_ctrl #(
    .NUM_BANKS(4), .BANK_AW(4), .DATA_W(32), .CLEAR_ON_RESET(1)
  ) dut4 (
    .CLK(CLK), .RST(RST), .req_i(req4), .we_i(we4), .addr_i(addr4),
    .wdata_i(wd4), .be_i(be4), .ready_o(ready4), .rvalid_o(rvalid4),
    .rdata_o(rdata4), .err_o(err4), .bank_wren_o(wren4), .busy_clear_o(busy4)
  );

  banked_data_mem_ctrl #(
    .NUM_BANKS(3), .BANK_AW(4), .DATA_W(32), .CLEAR_ON_RESET(0)
  ) dut3 (
    .CLK(CLK), .RST(RST), .req_i(req3), .we_i(we3), .addr_i(addr3),
    .wdata_i(wd3), .be_i(be3), .ready_o(ready3), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .err_o(err3), .bank_wren_o(wren3), .busy_clear_o(busy3)
  );

  function automatic logic [31:0] mk(input int bank, input int off);
    return (32'(bank) << 4) | 32'(off);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb(input string tag, input logic has, input logic [32:0] e,
                    input logic rv, input logic er, input logic [31:0] rd);
    chk({tag, ".rvalid"}, 32'(rv), 32'(has));
    chk({tag, ".err"}, 32'(er), 32'(e[32]));
    chk({tag, ".rdata"}, rd, e[31:0]);
  endtask

  task automatic tick();
    logic [32:0] e;
    logic        h;
    @(posedge CLK);
    #1;
    h = (q4.size() > 0);
    e = '0;
    if (h) e = q4.pop_front();
    sb("d4", h, e, rvalid4, err4, rdata4);
    h = (q3.size() > 0);
    e = '0;
    if (h) e = q3.pop_front();
    sb("d3", h, e, rvalid3, err3, rdata3);
    @(negedge CLK);
  endtask

  task automatic drive4(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    req4 = r; we4 = w; addr4 = a; wd4 = d; be4 = b;
  endtask

  task automatic drive3(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    req3 = r; we3 = w; addr3 = a; wd3 = d; be3 = b;
  endtask

  initial begin
    drive4(0, 0, 0, 0, 0);
    drive3(0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    #1;
    chk("rst.ready4", 32'(ready4), 0);
    chk("rst.rvalid4", 32'(rvalid4), 0);
    chk("rst.err4", 32'(err4), 0);
    chk("rst.rdata4", rdata4, 0);
    chk("rst.wren4", 32'(wren4), 0);
    chk("rst.busy4", 32'(busy4), 1);
    chk("rst.ready3", 32'(ready3), 0);
    chk("rst.busy3", 32'(busy3), 0);

    // Release, abort the clear at word 7 with a one-cycle reset pulse.
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("clr.busy_at_release", 32'(busy4), 1);
    repeat (7) tick();
    chk("clr.ready3_run", 32'(ready3), 1);
    RST = 1'b1;
    #1;
    chk("abort.ready4", 32'(ready4), 0);
    chk("abort.busy4", 32'(busy4), 1);
    chk("abort.ready3", 32'(ready3), 0);
    chk("abort.rvalid4", 32'(rvalid4), 0);
    tick();

    // Read held from release: no accept until ready rises after a full clear.
    drive4(1, 0, 32'h0000_0012, 0, 0);
    RST = 1'b0;
    #1;
    chk("clr2.busy0", 32'(busy4), 1);
    chk("clr2.ready0", 32'(ready4), 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("clr2.busy", 32'(busy4), 1);
      chk("clr2.ready", 32'(ready4), 0);
    end
    tick();
    chk("clr2.busy_done", 32'(busy4), 0);
    chk("clr2.ready_up", 32'(ready4), 1);
    q4.push_back({1'b0, 32'h0000_0000});
    tick();

    // Byte-enable merge, then immediate read-after-write.
    drive4(1, 1, mk(2, 5), 32'hDEAD_BEEF, 4'b1111);
    #1 chk("wr1.wren4", 32'(wren4), 32'h4);
    tick();
    drive4(1, 1, mk(2, 5), 32'h0000_00AA, 4'b0001);
    #1 chk("wr2.wren4", 32'(wren4), 32'h4);
    tick();
    drive4(1, 0, mk(2, 5), 0, 0);
    q4.push_back({1'b0, 32'hDEAD_BEAA});
    tick();

    // Back-to-back reads from different banks exercise the delayed select.
    drive4(1, 1, mk(0, 1), 32'h1111_1111, 4'hF);
    #1 chk("wr3.wren4", 32'(wren4), 32'h1);
    tick();
    drive4(1, 1, mk(3, 1), 32'h3333_3333, 4'hF);
    #1 chk("wr4.wren4", 32'(wren4), 32'h8);
    tick();
    drive4(1, 0, mk(0, 1), 0, 0);
    q4.push_back({1'b0, 32'h1111_1111});
    tick();
    drive4(1, 0, mk(3, 1), 0, 0);
    q4.push_back({1'b0, 32'h3333_3333});
    tick();
    drive4(1, 1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF);
    #1 chk("errwr.wren4", 32'(wren4), 0);
    q4.push_back({1'b1, 32'h0});
    tick();
    drive4(0, 0, 0, 0, 0);
    tick();

    // Three-bank instance: index 3 and high address bits are unmapped.
    drive3(1, 1, mk(0, 0), 32'h5A5A_5A5A, 4'hF);
    #1 chk("d3.wr.wren", 32'(wren3), 32'h1);
    tick();
    drive3(1, 0, mk(3, 0), 0, 0);
    q3.push_back({1'b1, 32'h0});
    tick();
    drive3(1, 1, mk(3, 0), 32'hFFFF_FFFF, 4'hF);
    #1 chk("d3.errwr.wren", 32'(wren3), 0);
    q3.push_back({1'b1, 32'h0});
    tick();
    drive3(1, 0, 32'h0100_0000, 0, 0);
    q3.push_back({1'b1, 32'h0});
    tick();
    drive3(1, 0, mk(0, 0), 0, 0);
    q3.push_back({1'b0, 32'h5A5A_5A5A});
    tick();
    drive3(0, 0, 0, 0, 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_data_mem_ctrl.md
Name: banked_data_mem_ctrl

Overview:
- Parametrised successor to the processor's fixed four-bank data memory manager.
- Decodes a word address into NUM_BANKS on-chip RAM banks and gates per-bank write enables.
- Adds byte-enable writes, a req/ready/rvalid handshake, a correctly pipelined read-select mux, unmapped-address error reporting and optional zero-clear of all banks after reset.
- Sits between the CPU load/store stage and the data RAMs.

Parameters:
- NUM_BANKS, 4, number of RAM banks (1..16; need not be a power of two).
- BANK_AW, 16, word-address width inside one bank (bank depth = 2**BANK_AW words).
- DATA_W, 32, word width; multiple of 8.
- CLEAR_ON_RESET, 1, 1 = zero every bank word after reset before accepting requests.

Ports:
- CLK, in, 1, clock.
- RST, in, 1, asynchronous active-high reset.
- req_i, in, 1, request valid.
- we_i, in, 1, 1 = write, 0 = read.
- addr_i, in, 32, word address: bank index = addr_i[BANK_AW+SEL_W-1:BANK_AW], offset = addr_i[BANK_AW-1:0].
- wdata_i, in, DATA_W, write data.
- be_i, in, DATA_W/8, byte enables for writes.
- ready_o, out, 1, request accepted this cycle when req_i && ready_o.
- rvalid_o, out, 1, response valid (reads only, or any errored request).
- rdata_o, out, DATA_W, read data.
- err_o, out, 1, accompanies rvalid_o; address unmapped.
- bank_wren_o, out, NUM_BANKS, per-bank write strobes (debug/observe).
- busy_clear_o, out, 1, clear sequence in progress.

Behaviour:
- Clock CLK; reset RST asynchronous, active-high. SEL_W = max(1, clog2(NUM_BANKS)).
- Reset values: ready_o=0, rvalid_o=0, err_o=0, rdata_o=0, bank_wren_o=0, busy_clear_o=CLEAR_ON_RESET. Internal select pipeline register and clear counter are reset to 0.
- FSM states:
  - S_CLEAR: entered on reset release if CLEAR_ON_RESET=1. Counter clr_addr steps 0 to 2**BANK_AW-1, one word per cycle, writing 0 with all byte enables to every bank at once. ready_o=0 and busy_clear_o=1. The cycle after the last word, go to S_RUN.
  - S_RUN: entered directly from reset if CLEAR_ON_RESET=0. ready_o=1 continuously.
- Requests during S_CLEAR are not accepted; the master holds req_i and its payload stable.
- Accept condition: req_i && ready_o. Throughput is 1 request per cycle.
- Error condition: addr_i[31:BANK_AW+SEL_W] != 0, or bank index >= NUM_BANKS.
- Write accept, mapped address:
  - bank_wren_o[bank] = 1 combinationally that cycle.
  - RAM updates on the next edge for bytes with be_i=1 only; other bytes unchanged.
  - No response is generated.
- Read accept, mapped address:
  - Bank RAM read latency is 1 cycle.
  - The bank index is registered at accept, and rdata_o is muxed with that registered index, never the live address.
  - rvalid_o=1 and rdata_o = word in the following cycle.
- Errored request (read or write):
  - No bank is written.
  - Next cycle: rvalid_o=1, err_o=1, rdata_o=0.
- rvalid_o, err_o and rdata_o are single-cycle pulses. When rvalid_o=0, rdata_o holds 0.
- Read and write to the same word in consecutive cycles: the read returns the newly written data (write first, then read).
- Simultaneous read of a word in the same cycle as its write is impossible: single request per cycle.
- RST asserted mid-clear or mid-transaction:
  - All outputs return to reset values immediately.
  - Any pending response is dropped.
  - Clear restarts from word 0.
  - RAM contents are not guaranteed during reset.

Decomposition:
- Package dmem_pkg: state enum (S_CLEAR, S_RUN) and a sel_width(NUM_BANKS) function.
- Sub-module dmem_bank: single-port inferred RAM with byte-enable write and registered read, parametrised by BANK_AW and DATA_W. Instantiated NUM_BANKS times in a generate loop.
- Top holds: FSM, clear counter, decode, select pipeline and output mux.

Test Plan:
- CLEAR_ON_RESET=1, BANK_AW=4: release RST → busy_clear_o high exactly 16 cycles, then ready_o=1. Read 0x00012 → rvalid_o next cycle, rdata_o=0x00000000.
- Write 0xDEADBEEF to 0x2_0005 with be=4'b1111, then write 0x000000AA with be=4'b0001 → read returns 0xDEADBEAA. bank_wren_o=4'b0100 on both write cycles.
- Back-to-back reads of 0x0_0001 (=0x11111111) then 0x3_0001 (=0x33333333) → rdata_o 0x11111111 then 0x33333333 on consecutive cycles (checks delayed select).
- NUM_BANKS=3, read 0x3_0000 and write 0x3_0000 → each gives rvalid_o=1, err_o=1, rdata_o=0. bank_wren_o stays 0; bank 0 word 0 unchanged. addr 0x0100_0000 → err_o=1.
- req_i held high from reset release → first accept on the cycle ready_o rises; no rvalid_o earlier.
- Assert RST at clear word 7 for one cycle → outputs zero at once; clear restarts, lasting a full 2**BANK_AW cycles.
